smash_ni_rx: RTL and testbench

//  Receive side of the network interface. Drains flits from a smash_fifo
//  (the router ejection buffer), checks the destination, strips headers and

---
 rtl/smash_pkg.sv | 35 +++
 rtl/smash_fifo.sv | 47 ++++
 rtl/smash_flit_decode.sv | 28 ++
 rtl/smash_ni_rx.sv | 156 +++++++++++++++
 tb/tb_smash_ni_rx.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/smash_pkg.sv
// Shared flit encodings, receiver states and field-position helpers for the
// smash network interface.
package smash_pkg;

  typedef enum logic [1:0] {
    FLIT_BODY      = 2'b00,
    FLIT_TAIL      = 2'b01,
    FLIT_HEAD      = 2'b10,
    FLIT_HEAD_TAIL = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_DROP
  } rx_state_e;

  // Head layout below the type bits, MSB first: src, dst, len.
  function automatic int unsigned type_lsb(input int unsigned dw);
    return dw - 2;
  endfunction

  function automatic int unsigned src_msb(input int unsigned dw);
    return dw - 3;
  endfunction

  function automatic int unsigned dst_msb(input int unsigned dw, input int unsigned id);
    return dw - 3 - id;
  endfunction

  function automatic int unsigned len_msb(input int unsigned dw, input int unsigned id);
    return dw - 3 - 2 * id;
  endfunction

endpackage

// File: rtl/smash_fifo.sv
// Show-ahead FIFO used as the router ejection buffer; head word is valid on
// o_data whenever o_empty is low.
module smash_fifo #(
  parameter int unsigned ADDR_SIZE = 2,
  parameter int unsigned DATA_SIZE = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_write,
  input  logic [DATA_SIZE-1:0] i_data,
  output logic                 o_full,
  input  logic                 i_read,
  output logic [DATA_SIZE-1:0] o_data,
  output logic                 o_empty
);

  localparam int unsigned DEPTH = 1 << ADDR_SIZE;

  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [ADDR_SIZE:0]   wr_ptr;
  logic [ADDR_SIZE:0]   rd_ptr;
  logic                 do_write;
  logic                 do_read;

  assign o_empty  = (wr_ptr == rd_ptr);
  assign o_full   = (wr_ptr[ADDR_SIZE] != rd_ptr[ADDR_SIZE]) &&
                    (wr_ptr[ADDR_SIZE-1:0] == rd_ptr[ADDR_SIZE-1:0]);
  assign do_write = i_write && !o_full;
  assign do_read  = i_read && !o_empty;
  assign o_data   = mem[rd_ptr[ADDR_SIZE-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_write) begin
        mem[wr_ptr[ADDR_SIZE-1:0]] <= i_data;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_read) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/smash_flit_decode.sv
// Combinational split of a flit into type, head fields and payload.
module smash_flit_decode
  import smash_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned ID_SIZE   = 4,
  parameter int unsigned LEN_SIZE  = 8
) (
  input  logic [DATA_SIZE-1:0] flit,
  output logic [1:0]           ftype,
  output logic [ID_SIZE-1:0]   src,
  output logic [ID_SIZE-1:0]   dst,
  output logic [LEN_SIZE-1:0]  len,
  output logic [DATA_SIZE-3:0] payload
);

  localparam int unsigned TYPE_LSB = type_lsb(DATA_SIZE);
  localparam int unsigned SRC_MSB  = src_msb(DATA_SIZE);
  localparam int unsigned DST_MSB  = dst_msb(DATA_SIZE, ID_SIZE);
  localparam int unsigned LEN_MSB  = len_msb(DATA_SIZE, ID_SIZE);

  assign ftype   = flit[TYPE_LSB +: 2];
  assign src     = flit[SRC_MSB -: ID_SIZE];
  assign dst     = flit[DST_MSB -: ID_SIZE];
  assign len     = flit[LEN_MSB -: LEN_SIZE];
  assign payload = flit[DATA_SIZE-3:0];

endmodule

// File: rtl/smash_ni_rx.sv
// Network-interface receiver: drains the ejection FIFO, filters by destination,
// strips heads and streams payload words over a valid/ready port.
module smash_ni_rx
  import smash_pkg::*;
#(
  parameter int unsigned          DATA_SIZE = 32,
  parameter int unsigned          ID_SIZE   = 4,
  parameter int unsigned          LEN_SIZE  = 8,
  parameter logic [ID_SIZE-1:0]   NODE_ID   = 4'h3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_fifo_empty,
  input  logic [DATA_SIZE-1:0]  i_fifo_data,
  output logic                  o_fifo_read,
  output logic                  o_hdr_valid,
  output logic [ID_SIZE-1:0]    o_src,
  output logic [LEN_SIZE-1:0]   o_len,
  output logic                  o_valid,
  output logic [DATA_SIZE-3:0]  o_data,
  output logic                  o_last,
  input  logic                  i_ready,
  output logic                  o_err
);

  rx_state_e             state, state_n;
  logic [LEN_SIZE-1:0]   cnt, cnt_n;
  logic [1:0]            ftype_raw;
  flit_type_e            ftype;
  logic [ID_SIZE-1:0]    f_src;
  logic [ID_SIZE-1:0]    f_dst;
  logic [LEN_SIZE-1:0]   f_len;
  logic [DATA_SIZE-3:0]  f_payload;
  logic                  is_head;
  logic                  stall;
  logic                  pop;
  logic                  take_head;
  logic                  emit, emit_last;
  logic                  latch_hdr;
  logic                  hdr_n, err_n;

  smash_flit_decode #(
    .DATA_SIZE (DATA_SIZE),
    .ID_SIZE   (ID_SIZE),
    .LEN_SIZE  (LEN_SIZE)
  ) u_decode (
    .flit    (i_fifo_data),
    .ftype   (ftype_raw),
    .src     (f_src),
    .dst     (f_dst),
    .len     (f_len),
    .payload (f_payload)
  );

  assign ftype   = flit_type_e'(ftype_raw);
  assign is_head = ftype_raw[1];

  // A full output register blocks payload pops, and also holds back any head
  // so o_hdr_valid never overlaps a pending word of the previous packet.
  assign stall       = o_valid && !i_ready && (state == ST_PAYLOAD || is_head);
  assign pop         = !i_rst && !i_fifo_empty && !stall;
  assign o_fifo_read = pop;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    take_head = 1'b0;
    emit      = 1'b0;
    emit_last = 1'b0;
    latch_hdr = 1'b0;
    hdr_n     = 1'b0;
    err_n     = 1'b0;

    if (pop) begin
      unique case (state)
        ST_PAYLOAD: begin
          unique case (ftype)
            FLIT_BODY: begin
              emit  = 1'b1;
              cnt_n = (cnt == '1) ? cnt : cnt + 1'b1;
            end
            FLIT_TAIL: begin
              emit      = 1'b1;
              emit_last = 1'b1;
              state_n   = ST_IDLE;
              err_n     = ((LEN_SIZE+1)'(cnt) + 1'b1) != (LEN_SIZE+1)'(o_len);
            end
            default: begin
              err_n     = 1'b1;
              take_head = 1'b1;
            end
          endcase
        end
        ST_DROP: begin
          if (is_head) begin
            err_n     = 1'b1;
            take_head = 1'b1;
          end else if (ftype == FLIT_TAIL) begin
            state_n = ST_IDLE;
          end
        end
        default: begin
          if (is_head) begin
            take_head = 1'b1;
          end else begin
            err_n   = 1'b1;
            state_n = (ftype == FLIT_BODY) ? ST_DROP : ST_IDLE;
          end
        end
      endcase

      if (take_head) begin
        if (f_dst == NODE_ID) begin
          latch_hdr = 1'b1;
          hdr_n     = 1'b1;
          cnt_n     = '0;
          state_n   = (ftype == FLIT_HEAD) ? ST_PAYLOAD : ST_IDLE;
        end else begin
          state_n   = (ftype == FLIT_HEAD) ? ST_DROP : ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      o_hdr_valid <= 1'b0;
      o_err       <= 1'b0;
      o_src       <= '0;
      o_len       <= '0;
      o_valid     <= 1'b0;
      o_data      <= '0;
      o_last      <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      o_hdr_valid <= hdr_n;
      o_err       <= err_n;
      if (latch_hdr) begin
        o_src <= f_src;
        o_len <= f_len;
      end
      if (emit) begin
        o_valid <= 1'b1;
        o_data  <= f_payload;
        o_last  <= emit_last;
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
        o_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_smash_ni_rx.sv
// Directed bench: smash_fifo feeding smash_ni_rx, table-driven packets plus
// hand-written backpressure and reset sequences.
module tb_smash_ni_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_rst;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        fifo_full;
  logic        fifo_empty;
  logic [31:0] fifo_data;
  logic        fifo_read;
  logic        hdr_valid;
  logic [3:0]  src;
  logic [7:0]  len;
  logic        valid;
  logic [29:0] data;
  logic        last;
  logic        ready;
  logic        err;

  always #5 clk = ~clk;

  smash_fifo #(.ADDR_SIZE(2), .DATA_SIZE(32)) u_fifo (
    .i_clk   (clk),
    .i_rst   (fifo_rst),
    .i_write (wr_en),
    .i_data  (wr_data),
    .o_full  (fifo_full),
    .i_read  (fifo_read),
    .o_data  (fifo_data),
    .o_empty (fifo_empty)
  );

  smash_ni_rx #(.DATA_SIZE(32), .ID_SIZE(4), .LEN_SIZE(8), .NODE_ID(4'h3)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_fifo_empty (fifo_empty),
    .i_fifo_data  (fifo_data),
    .o_fifo_read  (fifo_read),
    .o_hdr_valid  (hdr_valid),
    .o_src        (src),
    .o_len        (len),
    .o_valid      (valid),
    .o_data       (data),
    .o_last       (last),
    .i_ready      (ready),
    .o_err        (err)
  );

  localparam logic [1:0] T_BODY = 2'b00, T_TAIL = 2'b01, T_HEAD = 2'b10, T_HT = 2'b11;

  typedef struct {
    int               n_flits;
    logic [5:0][31:0] flits;
    int               n_words;
    logic [3:0][29:0] words;
    logic [3:0]       lasts;
    int               n_hdr;
    logic [3:0]       src;
    logic [7:0]       len;
    int               n_err;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [29:0] mon_words[$];
  logic        mon_lasts[$];
  int          mon_hdr = 0;
  int          mon_err = 0;
  int          bad_reads = 0;

  always @(negedge clk) begin
    if (valid && ready) begin
      mon_words.push_back(data);
      mon_lasts.push_back(last);
    end
    if (hdr_valid) mon_hdr++;
    if (err) mon_err++;
    if (fifo_read && fifo_empty) bad_reads++;
  end

  function automatic logic [31:0] hd(input logic [1:0] t, input logic [3:0] s,
                                     input logic [3:0] d, input logic [7:0] l);
    return {t, s, d, l, 14'h0};
  endfunction

  function automatic logic [31:0] pl(input logic [1:0] t, input logic [29:0] p);
    return {t, p};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] f);
    int t = 0;
    while (fifo_full && t < 100) begin
      step();
      t++;
    end
    chk("push_timeout", 32'(t < 100), 32'd1);
    wr_en   = 1'b1;
    wr_data = f;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle();
    int idle = 0;
    int t = 0;
    while (idle < 3 && t < 300) begin
      step();
      t++;
      if (fifo_empty && !valid) idle++;
      else idle = 0;
    end
    chk("idle_timeout", 32'(idle >= 3), 32'd1);
  endtask

  task automatic mon_clear();
    mon_words.delete();
    mon_lasts.delete();
    mon_hdr = 0;
    mon_err = 0;
  endtask

  task automatic check_words(input string tag, input int n, input logic [3:0][29:0] w,
                             input logic [3:0] l);
    chk({tag, "_nwords"}, 32'(mon_words.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < mon_words.size()) begin
        chk($sformatf("%s_word%0d", tag, i), 32'(mon_words[i]), 32'(w[i]));
        chk($sformatf("%s_last%0d", tag, i), 32'(mon_lasts[i]), 32'(l[i]));
      end
    end
  endtask

  vec_t vecs[6];

  initial begin
    // Packet 1: basic delivery
    vecs[0].n_flits = 3;
    vecs[0].flits[0] = hd(T_HEAD, 4'd5, 4'd3, 8'd2);
    vecs[0].flits[1] = pl(T_BODY, 30'h0AAA5555);
    vecs[0].flits[2] = pl(T_TAIL, 30'h0AFEBABE);
    vecs[0].n_words = 2; vecs[0].words[0] = 30'h0AAA5555; vecs[0].words[1] = 30'h0AFEBABE;
    vecs[0].lasts = 4'b0010; vecs[0].n_hdr = 1; vecs[0].src = 4'd5; vecs[0].len = 8'd2;
    vecs[0].n_err = 0;
    // Foreign packet dropped, then head-tail for us
    vecs[1].n_flits = 3;
    vecs[1].flits[0] = hd(T_HEAD, 4'd2, 4'd7, 8'd1);
    vecs[1].flits[1] = pl(T_TAIL, 30'h123);
    vecs[1].flits[2] = hd(T_HT, 4'd1, 4'd3, 8'd0);
    vecs[1].n_words = 0; vecs[1].words = '0; vecs[1].lasts = '0;
    vecs[1].n_hdr = 1; vecs[1].src = 4'd1; vecs[1].len = 8'd0; vecs[1].n_err = 0;
    // Length mismatch
    vecs[2].n_flits = 3;
    vecs[2].flits[0] = hd(T_HEAD, 4'd6, 4'd3, 8'd3);
    vecs[2].flits[1] = pl(T_BODY, 30'h111);
    vecs[2].flits[2] = pl(T_TAIL, 30'h222);
    vecs[2].n_words = 2; vecs[2].words[0] = 30'h111; vecs[2].words[1] = 30'h222;
    vecs[2].lasts = 4'b0010; vecs[2].n_hdr = 1; vecs[2].src = 4'd6; vecs[2].len = 8'd3;
    vecs[2].n_err = 1;
    // Orphans then a valid packet
    vecs[3].n_flits = 5;
    vecs[3].flits[0] = pl(T_BODY, 30'h1);
    vecs[3].flits[1] = pl(T_BODY, 30'h2);
    vecs[3].flits[2] = pl(T_TAIL, 30'h3);
    vecs[3].flits[3] = hd(T_HEAD, 4'd9, 4'd3, 8'd1);
    vecs[3].flits[4] = pl(T_TAIL, 30'h0CAFE);
    vecs[3].n_words = 1; vecs[3].words = '0; vecs[3].words[0] = 30'h0CAFE;
    vecs[3].lasts = 4'b0001; vecs[3].n_hdr = 1; vecs[3].src = 4'd9; vecs[3].len = 8'd1;
    vecs[3].n_err = 1;
    // Packet abandoned by a new head
    vecs[4].n_flits = 4;
    vecs[4].flits[0] = hd(T_HEAD, 4'd4, 4'd3, 8'd3);
    vecs[4].flits[1] = pl(T_BODY, 30'h10);
    vecs[4].flits[2] = hd(T_HEAD, 4'd7, 4'd3, 8'd1);
    vecs[4].flits[3] = pl(T_TAIL, 30'h20);
    vecs[4].n_words = 2; vecs[4].words[0] = 30'h10; vecs[4].words[1] = 30'h20;
    vecs[4].lasts = 4'b0010; vecs[4].n_hdr = 2; vecs[4].src = 4'd7; vecs[4].len = 8'd1;
    vecs[4].n_err = 1;
    // Foreign head-tail ignored, then ours
    vecs[5].n_flits = 3;
    vecs[5].flits[0] = hd(T_HT, 4'd2, 4'd5, 8'd0);
    vecs[5].flits[1] = hd(T_HEAD, 4'd3, 4'd3, 8'd1);
    vecs[5].flits[2] = pl(T_TAIL, 30'h33);
    vecs[5].n_words = 1; vecs[5].words = '0; vecs[5].words[0] = 30'h33;
    vecs[5].lasts = 4'b0001; vecs[5].n_hdr = 1; vecs[5].src = 4'd3; vecs[5].len = 8'd1;
    vecs[5].n_err = 0;

    rst = 1'b1; fifo_rst = 1'b1; wr_en = 1'b0; wr_data = '0; ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_hdr", 32'(hdr_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_src", 32'(src), 32'd0);
    chk("rst_len", 32'(len), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_last", 32'(last), 32'd0);
    chk("rst_read", 32'(fifo_read), 32'd0);
    step();
    rst = 1'b0; fifo_rst = 1'b0;
    step();

    for (int v = 0; v < 6; v++) begin
      mon_clear();
      for (int f = 0; f < vecs[v].n_flits; f++) push(vecs[v].flits[f]);
      wait_idle();
      check_words($sformatf("v%0d", v), vecs[v].n_words, vecs[v].words, vecs[v].lasts);
      chk($sformatf("v%0d_nhdr", v), 32'(mon_hdr), 32'(vecs[v].n_hdr));
      chk($sformatf("v%0d_src", v), 32'(src), 32'(vecs[v].src));
      chk($sformatf("v%0d_len", v), 32'(len), 32'(vecs[v].len));
      chk($sformatf("v%0d_nerr", v), 32'(mon_err), 32'(vecs[v].n_err));
    end

    // Backpressure: first word held for three cycles, no pops meanwhile
    begin
      int t = 0;
      logic [3:0][29:0] w;
      mon_clear();
      push(hd(T_HEAD, 4'd5, 4'd3, 8'd2));
      push(pl(T_BODY, 30'h0AAA5555));
      push(pl(T_TAIL, 30'h0AFEBABE));
      while (!valid && t < 20) begin
        step();
        t++;
      end
      ready = 1'b0;
      chk("bp_first_valid", 32'(valid), 32'd1);
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        chk($sformatf("bp_valid%0d", c), 32'(valid), 32'd1);
        chk($sformatf("bp_data%0d", c), 32'(data), 32'h0AAA5555);
        chk($sformatf("bp_read%0d", c), 32'(fifo_read), 32'd0);
        step();
      end
      ready = 1'b1;
      wait_idle();
      w = '0; w[0] = 30'h0AAA5555; w[1] = 30'h0AFEBABE;
      check_words("bp", 2, w, 4'b0010);
      chk("bp_nerr", 32'(mon_err), 32'd0);
      chk("bp_nhdr", 32'(mon_hdr), 32'd1);
    end

    // Reset after the first body of a len=4 packet
    begin
      int t = 0;
      logic [3:0][29:0] w;
      push(hd(T_HEAD, 4'd5, 4'd3, 8'd4));
      push(pl(T_BODY, 30'h41));
      while (!valid && t < 20) begin
        step();
        t++;
      end
      chk("rs_first_valid", 32'(valid), 32'd1);
      rst = 1'b1;
      ready = 1'b0;
      step();
      @(negedge clk);
      chk("rs_valid", 32'(valid), 32'd0);
      chk("rs_src", 32'(src), 32'd0);
      chk("rs_len", 32'(len), 32'd0);
      chk("rs_last", 32'(last), 32'd0);
      step();
      rst = 1'b0;
      ready = 1'b1;
      mon_clear();
      push(pl(T_BODY, 30'h42));
      push(pl(T_BODY, 30'h43));
      push(pl(T_TAIL, 30'h44));
      push(hd(T_HEAD, 4'd8, 4'd3, 8'd1));
      push(pl(T_TAIL, 30'h55));
      wait_idle();
      w = '0; w[0] = 30'h55;
      check_words("rs", 1, w, 4'b0001);
      chk("rs_nerr", 32'(mon_err), 32'd1);
      chk("rs_nhdr", 32'(mon_hdr), 32'd1);
      chk("rs_src8", 32'(src), 32'd8);
    end

    chk("read_while_empty", 32'(bad_reads), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
